// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl_pkg: ALU op codes, instruction opcodes and FSM state type shared by the issue controller.
package alu_issue_ctrl_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;
    localparam logic [3:0] ALU_NOR   = 4'b1100;

    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    // CBZ is identified by its top eight bits only
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_issue_ctrl_decode.sv
// alu_op_decode: maps instruction bits [31:21] to an ALU op code and flags unsupported opcodes.
module alu_op_decode
    import alu_issue_ctrl_pkg::*;
(
    input  logic [10:0] opcode,
    output logic [3:0]  op,
    output logic        illegal
);

    logic is_addr;

    always_comb begin
        is_addr = opcode == OPC_ADD || opcode == OPC_LDUR || opcode == OPC_STUR;
        op      = is_addr                  ? ALU_ADD   :
                  opcode == OPC_SUB        ? ALU_SUB   :
                  opcode == OPC_ORR        ? ALU_ORR   :
                  opcode[10:3] == OPC_CBZ  ? ALU_PASSB : ALU_AND;
        illegal = !(is_addr || opcode == OPC_SUB || opcode == OPC_AND ||
                    opcode == OPC_ORR || opcode[10:3] == OPC_CBZ);
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts one instruction, drives the external ALU for one cycle and
// holds the captured response until the consumer takes it.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [10:0]      in_opcode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_illegal,
    output logic [15:0]      op_count
);

    state_t      state, state_nxt;
    logic [3:0]  dec_op;
    logic        dec_illegal;
    logic        accept;
    logic        done;
    logic [15:0] count;

    alu_op_decode u_decode (
        .opcode  (in_opcode),
        .op      (dec_op),
        .illegal (dec_illegal)
    );

    assign accept   = in_valid && in_ready;
    assign done     = out_valid && out_ready;
    assign op_count = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = dec_illegal ? RESP : EXEC;
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ALU-facing registers only load on a legal accept, so they stay quiet otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= ALU_AND;
            out_result  <= '0;
            out_zero    <= 1'b0;
            out_illegal <= 1'b0;
            count       <= '0;
        end else begin
            if (accept && !dec_illegal) begin
                alu_a  <= in_a;
                alu_b  <= in_b;
                alu_op <= dec_op;
            end
            if (accept && dec_illegal) begin
                out_result  <= '0;
                out_zero    <= 1'b0;
                out_illegal <= 1'b1;
            end
            if (state == EXEC) begin
                out_result  <= alu_result;
                out_zero    <= alu_zero;
                out_illegal <= 1'b0;
            end
            if (done) count <= count + 16'd1;
        end
    end

endmodule
